// File: rtl/bch_syndrome_unit_pkg.sv
// ============================================================================
// Module      : bch_syndrome_unit_pkg
// Description : Shared types, per-code constants and GF(2^m) helpers for the
//               BCH syndrome unit (fields m=6, m=8, m=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bch_syndrome_unit_pkg;

    localparam int SYN_W = 10;   // widest field element (m=10)
    localparam int CNT_W = 8;    // beat counter width

    typedef logic [SYN_W-1:0] syn_t;

    typedef enum logic [1:0] {
        CODE_63   = 2'd0,
        CODE_255  = 2'd1,
        CODE_1023 = 2'd2,
        CODE_BAD  = 2'd3
    } code_e;

    localparam int M_63   = 6;
    localparam int M_255  = 8;
    localparam int M_1023 = 10;

    localparam int T_63   = 2;
    localparam int T_255  = 2;
    localparam int T_1023 = 4;

    localparam logic [CNT_W-1:0] BEATS_63   = 8'd8;
    localparam logic [CNT_W-1:0] BEATS_255  = 8'd32;
    localparam logic [CNT_W-1:0] BEATS_1023 = 8'd128;

    // Primitive polynomials with the x^m term dropped (it is implied by the shift).
    localparam syn_t POLY_M6  = 10'h003;   // x^6 + x + 1
    localparam syn_t POLY_M8  = 10'h01D;   // x^8 + x^4 + x^3 + x^2 + 1
    localparam syn_t POLY_M10 = 10'h009;   // x^10 + x^3 + 1

    function automatic int code_t(input code_e c);
        int r;
        case (c)
            CODE_63:   r = T_63;
            CODE_255:  r = T_255;
            CODE_1023: r = T_1023;
            default:   r = 0;
        endcase
        return r;
    endfunction

    // Illegal code has no valid length, so any count mismatches it.
    function automatic logic [CNT_W-1:0] code_beats(input code_e c);
        logic [CNT_W-1:0] r;
        case (c)
            CODE_63:   r = BEATS_63;
            CODE_255:  r = BEATS_255;
            CODE_1023: r = BEATS_1023;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic syn_t gf_field_mask(input int m);
        return (syn_t'(1) << m) - syn_t'(1);
    endfunction

    function automatic syn_t gf_poly(input int m);
        syn_t r;
        case (m)
            6:       r = POLY_M6;
            8:       r = POLY_M8;
            default: r = POLY_M10;
        endcase
        return r;
    endfunction

    // Multiply by alpha (= x) once, reducing modulo the field polynomial.
    function automatic syn_t gf_mulx(input syn_t a, input int m);
        syn_t r;
        logic msb;
        msb = |(a & (syn_t'(1) << (m - 1)));
        r   = (a << 1) & gf_field_mask(m);
        if (msb) begin
            r = r ^ gf_poly(m);
        end
        return r;
    endfunction

    // Multiply by the constant alpha^n; n is always elaboration-constant here.
    function automatic syn_t gf_mul_apow(input syn_t a, input int n, input int m);
        syn_t r;
        r = a;
        for (int i = 0; i < n; i++) begin
            r = gf_mulx(r, m);
        end
        return r;
    endfunction

    // Squaring is linear in GF(2^m): Horner evaluation in y = alpha^2.
    function automatic syn_t gf_square(input syn_t a, input int m);
        syn_t acc;
        acc = '0;
        for (int i = SYN_W - 1; i >= 0; i--) begin
            acc = gf_mulx(gf_mulx(acc, m), m) ^ syn_t'(a[i]);
        end
        return acc;
    endfunction

endpackage : bch_syndrome_unit_pkg

`default_nettype wire

// File: rtl/bch_syn_slice.sv
// ============================================================================
// Module      : bch_syn_slice
// Description : One odd-syndrome accumulator S_K. Each beat folds DW hard bits
//               into S_K by Horner's rule over the field chosen by i_code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bch_syn_slice
    import bch_syndrome_unit_pkg::*;
#(
    parameter int K  = 1,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  code_e         i_code,
    input  logic          i_wen,
    input  logic          i_clear,
    input  logic [DW-1:0] i_data,
    output syn_t          o_s
);

    // S5/S7 only exist for the 4-error code; they sit at zero otherwise.
    localparam bit HIGH_ONLY = (K > 4);

    syn_t r_s;
    syn_t w_base;
    syn_t w_n6;
    syn_t w_n8;
    syn_t w_n10;
    syn_t w_next;

    // s*alpha^(DW*K) + sum d[j]*alpha^(j*K), evaluated MSB first.
    function automatic syn_t step(input syn_t s, input logic [DW-1:0] d, input int m);
        syn_t acc;
        acc = s;
        for (int j = DW - 1; j >= 0; j--) begin
            acc = gf_mul_apow(acc, K, m) ^ syn_t'(d[j]);
        end
        return acc;
    endfunction

    // Next-state: three fixed-field networks, selected by the code.
    always_comb begin
        w_base = i_clear ? '0 : r_s;
        w_n6   = step(w_base, i_data, M_63);
        w_n8   = step(w_base, i_data, M_255);
        w_n10  = step(w_base, i_data, M_1023);
        case (i_code)
            CODE_63:   w_next = HIGH_ONLY ? '0 : w_n6;
            CODE_255:  w_next = HIGH_ONLY ? '0 : w_n8;
            CODE_1023: w_next = w_n10;
            default:   w_next = HIGH_ONLY ? '0 : w_base;
        endcase
    end

    // Syndrome register; only beats move it, so it holds between frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s <= '0;
        end else if (i_wen) begin
            r_s <= w_next;
        end
    end

    assign o_s = r_s;

endmodule : bch_syn_slice

`default_nettype wire

// File: rtl/bch_syndrome_unit.sv
// ============================================================================
// Module      : bch_syndrome_unit
// Description : Odd-syndrome accumulator for BCH(63,51), (255,239), (1023,983).
//               Counts beats, detects frame end on the falling edge of i_wen,
//               flags wrong-length frames and pulses early-stop when clean.
//               Optional macro EVEN_SYNDROME_EN adds S2/S4/S6/S8 outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bch_syndrome_unit
    import bch_syndrome_unit_pkg::*;
#(
    parameter int DW = 8,
    parameter int SW = SYN_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_code,
    input  logic          i_clear_and_wen,
    input  logic          i_wen,
    input  logic [DW-1:0] i_data,
    output logic [SW-1:0] o_s1,
    output logic [SW-1:0] o_s3,
    output logic [SW-1:0] o_s5,
    output logic [SW-1:0] o_s7,
`ifdef EVEN_SYNDROME_EN
    output logic [SW-1:0] o_s2,
    output logic [SW-1:0] o_s4,
    output logic [SW-1:0] o_s6,
    output logic [SW-1:0] o_s8,
`endif
    output logic          o_done,
    output logic          o_early_stop_pulse,
    output logic          o_frame_err
);

    code_e            w_code;
    logic             w_clear;
    logic [DW-1:0]    w_data;
    syn_t             w_syn [4];
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_exp;
    logic             r_wen_d;
    logic             w_frame_end;
    logic             w_cnt_ok;
    logic             w_wide;
    logic             w_syn_zero;
    logic             r_done;
    logic             r_early;
    logic             r_err;

    assign w_code  = code_e'(i_code);
    assign w_clear = i_wen & i_clear_and_wen;

    // The 63-bit code is carried in 64 bits; the first beat's top bit is padding.
    always_comb begin
        w_data = i_data;
        if (w_code == CODE_63 && w_clear) begin
            w_data[DW-1] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        bch_syn_slice #(
            .K  (2 * gi + 1),
            .DW (DW)
        ) u_slice (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_code  (w_code),
            .i_wen   (i_wen),
            .i_clear (w_clear),
            .i_data  (w_data),
            .o_s     (w_syn[gi])
        );
    end

    assign w_exp       = code_beats(w_code);
    assign w_wide      = (code_t(w_code) > 2);
    assign w_frame_end = r_wen_d & ~i_wen;
    assign w_cnt_ok    = (w_code != CODE_BAD) && (r_cnt == w_exp);
    assign w_syn_zero  = (w_syn[0] == '0) && (w_syn[1] == '0) &&
                         (!w_wide || ((w_syn[2] == '0) && (w_syn[3] == '0)));

    // Beat counter: restarts on a clear beat, saturates at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= CNT_W'(1);
        end else if (i_wen && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed beat strobe for frame-end detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wen_d <= 1'b0;
        end else begin
            r_wen_d <= i_wen;
        end
    end

    // Frame-end status: done/early-stop pulses and the sticky length error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done  <= 1'b0;
            r_early <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done  <= w_frame_end;
            r_early <= w_frame_end & w_cnt_ok & w_syn_zero;
            if (w_clear) begin
                r_err <= 1'b0;
            end else if (w_frame_end) begin
                r_err <= ~w_cnt_ok;
            end
        end
    end

    assign o_s1               = SW'(w_syn[0]);
    assign o_s3               = SW'(w_syn[1]);
    assign o_s5               = SW'(w_syn[2]);
    assign o_s7               = SW'(w_syn[3]);
    assign o_done             = r_done;
    assign o_early_stop_pulse = r_early;
    assign o_frame_err        = r_err;

`ifdef EVEN_SYNDROME_EN
    syn_t r_s2;
    syn_t r_s4;
    syn_t r_s6;
    syn_t r_s8;
    syn_t w_s2;
    syn_t w_s4;
    syn_t w_s6;
    syn_t w_s8;

    function automatic syn_t sq_sel(input syn_t a, input code_e c);
        syn_t r;
        case (c)
            CODE_63:   r = gf_square(a, M_63);
            CODE_255:  r = gf_square(a, M_255);
            CODE_1023: r = gf_square(a, M_1023);
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Even syndromes follow from the odd ones by repeated squaring.
    always_comb begin
        w_s2 = sq_sel(w_syn[0], w_code);
        w_s4 = sq_sel(w_s2, w_code);
        w_s6 = w_wide ? sq_sel(w_syn[1], w_code) : '0;
        w_s8 = w_wide ? sq_sel(w_s4, w_code) : '0;
    end

    // Capture even syndromes on the frame-end cycle so they align with o_done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2 <= '0;
            r_s4 <= '0;
            r_s6 <= '0;
            r_s8 <= '0;
        end else if (w_frame_end) begin
            r_s2 <= w_s2;
            r_s4 <= w_s4;
            r_s6 <= w_s6;
            r_s8 <= w_s8;
        end
    end

    assign o_s2 = SW'(r_s2);
    assign o_s4 = SW'(r_s4);
    assign o_s6 = SW'(r_s6);
    assign o_s8 = SW'(r_s8);
`endif

endmodule : bch_syndrome_unit

`default_nettype wire

// File: tb/tb_bch_syndrome_unit.sv
// ============================================================================
// Module      : tb_bch_syndrome_unit
// Description : Self-checking bench for bch_syndrome_unit. Frames are driven
//               beat by beat; a polynomial-evaluation model pushes expected
//               results, which a monitor pops on o_done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bch_syndrome_unit;

    localparam int DW = 8;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    code;
    logic          clr;
    logic          wen;
    logic [DW-1:0] data;
    logic [SW-1:0] s1, s3, s5, s7;
    logic          done, early, ferr;
`ifdef EVEN_SYNDROME_EN
    logic [SW-1:0] s2, s4, s6, s8;
`endif

    always #5 clk = ~clk;

    bch_syndrome_unit #(.DW(DW), .SW(SW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_code             (code),
        .i_clear_and_wen    (clr),
        .i_wen              (wen),
        .i_data             (data),
        .o_s1               (s1),
        .o_s3               (s3),
        .o_s5               (s5),
        .o_s7               (s7),
`ifdef EVEN_SYNDROME_EN
        .o_s2               (s2),
        .o_s4               (s4),
        .o_s6               (s6),
        .o_s8               (s8),
`endif
        .o_done             (done),
        .o_early_stop_pulse (early),
        .o_frame_err        (ferr)
    );

    typedef struct {
        logic [9:0] s1, s3, s5, s7, s2, s4, s6, s8;
        logic       err;
        logic       early;
        logic       chk;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] beats[$];
    exp_t       last_exp;
    int         n_cmp = 0;
    int         n_bad = 0;

    // ---------------- reference GF model (full-polynomial arithmetic) -------
    function automatic int fld_m(input int c);
        return (c == 0) ? 6 : (c == 1) ? 8 : 10;
    endfunction

    function automatic int fld_poly(input int c);
        return (c == 0) ? 'h43 : (c == 1) ? 'h11D : 'h409;
    endfunction

    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b, input int c);
        int m, p, poly;
        m = fld_m(c);
        poly = fld_poly(c);
        p = 0;
        for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (int'(a) << i);
        for (int d = 19; d >= m; d--) if (p[d]) p = p ^ (poly << (d - m));
        return p[9:0];
    endfunction

    function automatic logic [9:0] gpow(input int e, input int c);
        logic [9:0] r, base;
        int ee;
        ee = e % ((1 << fld_m(c)) - 1);
        r = 10'd1;
        base = 10'd2;
        while (ee > 0) begin
            if (ee[0]) r = gmul(r, base, c);
            base = gmul(base, base, c);
            ee = ee >> 1;
        end
        return r;
    endfunction

    // ---------------- stimulus ----------------------------------------------
    task automatic put_beat(input logic [7:0] d, input logic c);
        @(negedge clk);
        wen  = 1'b1;
        clr  = c;
        data = d;
        if (c) beats.delete();
        beats.push_back(d);
    endtask

    // Drop wen and push the expected result of the beats since the last clear.
    task automatic end_frame();
        exp_t e;
        int   n, c, deg, nexp;
        @(negedge clk);
        wen  = 1'b0;
        clr  = 1'b0;
        data = '0;
        c = int'(code);
        n = beats.size();
        e = '{default: '0};
        if (c < 3) begin
            for (int b = 0; b < n; b++) begin
                for (int j = 0; j < 8; j++) begin
                    if (beats[b][j] && !(c == 0 && b == 0 && j == 7)) begin
                        deg = 8 * (n - 1 - b) + j;
                        e.s1 = e.s1 ^ gpow(deg, c);
                        e.s3 = e.s3 ^ gpow(3 * deg, c);
                        if (c == 2) begin
                            e.s5 = e.s5 ^ gpow(5 * deg, c);
                            e.s7 = e.s7 ^ gpow(7 * deg, c);
                        end
                    end
                end
            end
            e.s2 = gmul(e.s1, e.s1, c);
            e.s4 = gmul(e.s2, e.s2, c);
            e.s6 = (c == 2) ? gmul(e.s3, e.s3, c) : 10'd0;
            e.s8 = (c == 2) ? gmul(e.s4, e.s4, c) : 10'd0;
        end
        nexp    = (c == 0) ? 8 : (c == 1) ? 32 : 128;
        e.chk   = (c < 3);
        e.err   = (c == 3) || (n != nexp);
        e.early = !e.err && (e.s1 == 0) && (e.s3 == 0) && (e.s5 == 0) && (e.s7 == 0);
        sb.push_back(e);
        last_exp = e;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ------------------------------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1) begin
            if (early === 1'b1 && done !== 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL early_without_done: early=%b done=%b, required done=1", early, done);
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: done=1 with no frame outstanding");
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (ferr !== e.err) begin
                        n_bad++; $display("FAIL sb_frame_err: got %b, required %b", ferr, e.err);
                    end
                    n_cmp++;
                    if (early !== e.early) begin
                        n_bad++; $display("FAIL sb_early_stop: got %b, required %b", early, e.early);
                    end
                    if (e.chk) begin
                        n_cmp++;
                        if ({s1, s3, s5, s7} !== {e.s1, e.s3, e.s5, e.s7}) begin
                            n_bad++;
                            $display("FAIL sb_odd_syn: got %h %h %h %h, required %h %h %h %h",
                                     s1, s3, s5, s7, e.s1, e.s3, e.s5, e.s7);
                        end
`ifdef EVEN_SYNDROME_EN
                        n_cmp++;
                        if ({s2, s4, s6, s8} !== {e.s2, e.s4, e.s6, e.s8}) begin
                            n_bad++;
                            $display("FAIL sb_even_syn: got %h %h %h %h, required %h %h %h %h",
                                     s2, s4, s6, s8, e.s2, e.s4, e.s6, e.s8);
                        end
`endif
                    end
                end
            end
        end
    end

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; code = 2'd0; clr = 1'b0; wen = 1'b0; data = '0;
        #1;
        n_cmp++;
        if ({s1, s3, s5, s7, done, early, ferr} !== '0) begin
            n_bad++; $display("FAIL reset_state: got %h %h %h %h %b%b%b, required all 0",
                              s1, s3, s5, s7, done, early, ferr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s1, s3, s5, s7, done, early, ferr} !== '0) begin
            n_bad++; $display("FAIL post_reset_idle: got %h %h %h %h %b%b%b, required all 0",
                              s1, s3, s5, s7, done, early, ferr);
        end
    endtask

    task automatic test_zero_frame();
        code = 2'd0;
        for (int i = 0; i < 8; i++) put_beat(8'h00, i == 0);
        end_frame();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL done_too_early: got %b, required 0", done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || early !== 1'b1) begin
            n_bad++; $display("FAIL done_latency: done=%b early=%b, required 1 1", done, early);
        end
        wait_drain();
    endtask

    task automatic test_pad_bit();
        code = 2'd0;
        put_beat(8'h80, 1'b1);
        for (int i = 1; i < 8; i++) put_beat(8'h00, 1'b0);
        end_frame();
        @(negedge clk);
        n_cmp++;
        if (s1 !== 10'h000 || early !== 1'b1) begin
            n_bad++; $display("FAIL pad_mask: s1=%h early=%b, required 000 1", s1, early);
        end
        wait_drain();
    endtask

    task automatic test_code1_single();
        for (int k = 0; k < 2; k++) begin
            code = 2'd1;
            for (int i = 0; i < 32; i++) put_beat((i == 31) ? 8'(1 << k) : 8'h00, i == 0);
            end_frame();
            @(negedge clk);
            n_cmp++;
            if (k == 0 && (s1 !== 10'h001 || s3 !== 10'h001 || early !== 1'b0)) begin
                n_bad++; $display("FAIL code1_x0: s1=%h s3=%h early=%b, required 001 001 0", s1, s3, early);
            end
            if (k == 1 && (s1 !== 10'h002 || s3 !== 10'h008 || early !== 1'b0)) begin
                n_bad++; $display("FAIL code1_x1: s1=%h s3=%h early=%b, required 002 008 0", s1, s3, early);
            end
`ifdef EVEN_SYNDROME_EN
            if (k == 1) begin
                n_cmp++;
                if (s2 !== 10'h004 || s4 !== 10'h010) begin
                    n_bad++; $display("FAIL even_x1: s2=%h s4=%h, required 004 010", s2, s4);
                end
            end
`endif
            wait_drain();
        end
    endtask

    task automatic test_code2_single();
        code = 2'd2;
        for (int i = 0; i < 128; i++) put_beat((i == 126) ? 8'h04 : 8'h00, i == 0);
        end_frame();
        @(negedge clk);
        n_cmp++;
        if (s1 !== 10'h009 || s3 !== 10'h249 || s5 === 10'h000 || s7 === 10'h000 || early !== 1'b0) begin
            n_bad++; $display("FAIL code2_x10: s1=%h s3=%h s5=%h s7=%h early=%b, required 009 249 nz nz 0",
                              s1, s3, s5, s7, early);
        end
        wait_drain();
    endtask

    task automatic test_short_frame();
        code = 2'd0;
        for (int i = 0; i < 7; i++) put_beat(8'h00, i == 0);
        end_frame();
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || ferr !== 1'b1 || early !== 1'b0) begin
            n_bad++; $display("FAIL short_frame: done=%b err=%b early=%b, required 1 1 0", done, ferr, early);
        end
        wait_drain();
    endtask

    task automatic test_no_clear_continue();
        code = 2'd0;
        for (int i = 0; i < 4; i++) put_beat(8'($urandom), i == 0);
        end_frame();
        wait_drain();
        for (int i = 0; i < 4; i++) put_beat(8'($urandom), 1'b0);
        end_frame();
        wait_drain();
    endtask

    task automatic test_mid_clear();
        code = 2'd1;
        for (int i = 0; i < 5; i++) put_beat(8'($urandom), i == 0);
        for (int i = 0; i < 32; i++) put_beat(8'($urandom), i == 0);
        end_frame();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        code = 2'd2;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 128; i++) put_beat(8'($urandom), i == 0);
            end_frame();
        end
        wait_drain();
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({s1, s3, s5, s7} !== {last_exp.s1, last_exp.s3, last_exp.s5, last_exp.s7}) begin
            n_bad++; $display("FAIL syn_hold: got %h %h %h %h, required %h %h %h %h", s1, s3, s5, s7,
                              last_exp.s1, last_exp.s3, last_exp.s5, last_exp.s7);
        end
    endtask

    task automatic test_illegal_code();
        code = 2'd3;
        for (int i = 0; i < 4; i++) put_beat(8'($urandom), i == 0);
        end_frame();
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || ferr !== 1'b1) begin
            n_bad++; $display("FAIL illegal_code: done=%b err=%b, required 1 1", done, ferr);
        end
        wait_drain();
        code = 2'd2;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        code = 2'd2;
        for (int i = 0; i < 50; i++) put_beat(8'($urandom), i == 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0; wen = 1'b0; clr = 1'b0; data = '0;
        #1;
        n_cmp++;
        if ({s1, s3, s5, s7, done, early, ferr} !== '0) begin
            n_bad++; $display("FAIL async_reset: got %h %h %h %h %b%b%b, required all 0",
                              s1, s3, s5, s7, done, early, ferr);
        end
        beats.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) put_beat(8'h00, i == 0);
        end_frame();
        @(negedge clk);
        n_cmp++;
        if (early !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_early: got %b, required 1", early);
        end
        wait_drain();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_pad_bit();
        test_code1_single();
        test_code2_single();
        test_short_frame();
        test_no_clear_continue();
        test_mid_clear();
        test_back_to_back();
        test_illegal_code();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bch_syndrome_unit

`default_nettype wire

// File: doc/bch_syndrome_unit.md
Name: bch_syndrome_unit

Overview:
- Syndrome accumulator that sits directly downstream of the decoder control block.
- Each cycle it consumes 8 hard-decision bits, gated by the control block's clear-and-write and write strobes, and Horner-accumulates odd syndromes over GF(2^m).
- On frame end it presents the syndrome vector to the key-equation stage.
- It also returns the early-stop pulse to control when all syndromes are zero.

Parameters:
- DW, 8, hard bits per beat.
- SW, 10, syndrome register width (widest field, m=10).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_code  in  2  code select from control: 0=(63,51) m=6 t=2; 1=(255,239) m=8 t=2; 2=(1023,983) m=10 t=4; 3 illegal.
- i_clear_and_wen  in  1  first beat of a frame: discard old state and load this beat.
- i_wen  in  1  beat valid; high for every beat of a frame, including the first.
- i_data  in  DW  hard bits; bit 7 is the highest-degree coefficient of the beat; the first beat carries the highest degrees.
- o_s1, o_s3, o_s5, o_s7  out  SW each  odd syndromes, zero-extended above m.
- o_done  out  1  one-cycle pulse when the syndromes are final.
- o_early_stop_pulse  out  1  one-cycle pulse with o_done when all used syndromes are 0 and the frame is well-formed.
- o_frame_err  out  1  registered; wrong beat count seen on the last frame.

Behaviour:
- Reset (asynchronous): all syndromes, the beat counter, wen_d, o_done, o_early_stop_pulse and o_frame_err go to 0.
- Fields:
  - m=6: x^6+x+1.
  - m=8: x^8+x^4+x^3+x^2+1.
  - m=10: x^10+x^3+1.
  - All multipliers are constant-alpha XOR networks, muxed by i_code.
- Accumulate on a cycle with i_wen=1, for each k in {1,3,5,7}:
  - Sk <= Sk*alpha^(8k) + sum over j=0..7 of i_data[j]*alpha^(jk).
  - If i_clear_and_wen=1, the old Sk is treated as 0.
  - Results are reduced mod the selected polynomial; bits above m-1 are forced to 0.
- S5 and S7 are held at 0 when i_code != 2.
- Code 0 pad: the first beat's bit 7 (coefficient x^63) is masked to 0.
- Beat counter (8 bits):
  - Loads 1 on clear_and_wen; increments on other wen cycles.
  - Saturates at 255.
  - Expected count: 8, 32, 128 for codes 0, 1, 2.
- Frame end: detected as the registered falling edge of i_wen (wen_d=1, i_wen=0).
  - That cycle is registered, so o_done is high the cycle after the beat after the last beat (latency 1 after wen drops).
  - o_frame_err <= (count != expected).
  - o_early_stop_pulse = o_done & all-used-syndromes-zero & count == expected.
- Syndrome outputs:
  - Hold their value until the next clear_and_wen.
  - Change only on wen cycles, so they are stable from o_done onward.
- Boundary conditions:
  - clear_and_wen mid-frame: restarts the frame; the counter restarts; no o_done for the aborted frame.
  - wen without a preceding clear: keeps accumulating onto the held state; counted normally.
  - i_code is sampled continuously; control only changes it on core_set, before clear.
  - i_code=3: no accumulation; o_done still fires; o_frame_err=1.
- o_frame_err clears on the next clear_and_wen.

Optional Feature:
- Macro EVEN_SYNDROME_EN.
- When defined:
  - Adds outputs o_s2, o_s4, o_s6, o_s8 (SW each), registered on the frame-end cycle.
  - S2=S1^2, S4=S2^2, S6=S3^2, S8=S4^2 in the selected field.
  - They are valid with o_done; S6 and S8 are 0 unless code 2.
  - Early-stop is unchanged (odd syndromes only).
- When undefined: these ports and their logic are absent.

Decomposition:
- Shared package holds:
  - code enum (CODE_63, CODE_255, CODE_1023);
  - per-code M, T and expected beat count;
  - the three primitive polynomials;
  - the GF constant-multiply and square functions.
- One sub-module, bch_syn_slice: a single Sk accumulator parameterised by k, instantiated 4 times.

Test Plan:
- Code 0, all-zero data, 8 beats (clear on beat 1) -> o_done and o_early_stop_pulse high 1 cycle after wen falls; S1=S3=0; o_frame_err=0.
- Code 1, single 1 at x^0 (last beat, bit 0) -> S1=0x01, S3=0x01; no early stop. Same with a 1 at x^1 -> S1=0x02, S3=0x08.
- Code 2, single 1 at x^10 -> S1=0x009, S3=0x249; S5, S7 nonzero; no early stop.
- Code 0, only 7 beats -> o_done pulses; o_frame_err=1; no early stop even with zero data.
- Async reset asserted mid-frame in code 2 -> all outputs 0 immediately; a following fresh all-zero frame gives early stop.
- With EVEN_SYNDROME_EN, code 1 error at x^1 -> S2=0x04, S4=0x10.
